axi_lite_mem_arbiter: RTL and testbench

- Two-master, one-slave AXI4-Lite arbiter that shares the single memory port between the instruction fetch unit (m0, read-only) and the load/store unit (m1, read/write).
- Sits between the core's IFU/LSU AXI4-Lite masters and the memory/SRAM slave.
- Exactly one transaction is in flight at a time. A grant is held from address issue until the final response handshake.

---
 rtl/axi_lite_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter, one transaction in flight.
// Optional build macro AXI_ARB_LSU_PRIO_EN: LSU wins every tie (fixed priority) instead of round-robin.
module axi_lite_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic                busy,
  output logic                owner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [1:0] r_state;
  logic       r_owner;
  logic       r_rr_last;
  logic       r_ar_done;
  logic       r_aw_done;
  logic       r_w_done;

  logic w_r0, w_r1, w_m1_wreq, w_pick;
  logic w_rd, w_wr, w_rd0, w_rd1;

  assign w_r0      = m0_arvalid;
  assign w_m1_wreq = m1_awvalid | m1_wvalid;
  assign w_r1      = w_m1_wreq | m1_arvalid;

`ifdef AXI_ARB_LSU_PRIO_EN
  assign w_pick = w_r1;
`else
  assign w_pick = (w_r0 & w_r1) ? ~r_rr_last : w_r1;
`endif

  assign w_rd  = (r_state == S_RD);
  assign w_wr  = (r_state == S_WR);
  assign w_rd0 = w_rd & ~r_owner;
  assign w_rd1 = w_rd & r_owner;

  // Read routing: only the owning master is connected, and AR is suppressed once accepted
  assign s_araddr   = w_rd1 ? m1_araddr : (w_rd0 ? m0_araddr : '0);
  assign s_arvalid  = ~r_ar_done & ((w_rd0 & m0_arvalid) | (w_rd1 & m1_arvalid));
  assign s_rready   = (w_rd0 & m0_rready) | (w_rd1 & m1_rready);
  assign m0_arready = w_rd0 & ~r_ar_done & s_arready;
  assign m1_arready = w_rd1 & ~r_ar_done & s_arready;
  assign m0_rdata   = w_rd0 ? s_rdata : '0;
  assign m0_rresp   = w_rd0 ? s_rresp : '0;
  assign m0_rvalid  = w_rd0 & s_rvalid;
  assign m1_rdata   = w_rd1 ? s_rdata : '0;
  assign m1_rresp   = w_rd1 ? s_rresp : '0;
  assign m1_rvalid  = w_rd1 & s_rvalid;

  // Write routing: LSU only, AW and W each suppressed independently after their handshake
  assign s_awaddr   = w_wr ? m1_awaddr : '0;
  assign s_awvalid  = w_wr & m1_awvalid & ~r_aw_done;
  assign m1_awready = w_wr & ~r_aw_done & s_awready;
  assign s_wdata    = w_wr ? m1_wdata : '0;
  assign s_wstrb    = w_wr ? m1_wstrb : '0;
  assign s_wvalid   = w_wr & m1_wvalid & ~r_w_done;
  assign m1_wready  = w_wr & ~r_w_done & s_wready;
  assign s_bready   = w_wr & m1_bready;
  assign m1_bvalid  = w_wr & s_bvalid;
  assign m1_bresp   = w_wr ? s_bresp : '0;

  assign busy  = (r_state != S_IDLE);
  assign owner = r_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_r0 | w_r1) begin
            r_owner   <= w_pick;
            r_rr_last <= w_pick;
            r_state   <= (w_pick & w_m1_wreq) ? S_WR : S_RD;
          end
        end
        S_RD: begin
          if (s_arvalid & s_arready) r_ar_done <= 1'b1;
          if (s_rvalid & s_rready) begin
            r_state   <= S_IDLE;
            r_ar_done <= 1'b0;
          end
        end
        S_WR: begin
          if (s_awvalid & s_awready) r_aw_done <= 1'b1;
          if (s_wvalid & s_wready)   r_w_done  <= 1'b1;
          if (s_bvalid & s_bready) begin
            r_state   <= S_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Bench for axi_lite_mem_arbiter: behavioural memory slave, per-master driver tasks, response scoreboard.
module tb_axi_lite_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CYC = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [AW-1:0] m0_araddr, m1_araddr, m1_awaddr, s_araddr, s_awaddr;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [DW-1:0] m0_rdata, m1_rdata, m1_wdata, s_rdata, s_wdata;
  logic [DW/8-1:0] m1_wstrb, s_wstrb;
  logic [1:0] m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic s_wvalid, s_wready, s_bvalid, s_bready, busy, owner;

  assign s_arready = 1'b1;
  assign s_awready = 1'b1;
  assign s_wready  = 1'b1;

  axi_lite_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .busy(busy), .owner(owner)
  );

  // Memory slave: 2-cycle read latency, addresses with top nibble 0xF answer SLVERR
  logic [31:0] mem [64];
  logic        preload;
  int          sl_cnt;
  logic [31:0] sl_raddr, sl_waddr, sl_wdata;
  logic [3:0]  sl_wstrb;
  logic        aw_got, w_got;

  function automatic int idx(input logic [31:0] a);
    return int'({a[13:12], a[5:2]});
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h0000_0413;
      mem[1]  <= 32'h0011_2233;
      mem[16] <= 32'h1000_AAAA;
    end
    if (rst) begin
      s_rvalid <= 1'b0; s_bvalid <= 1'b0; sl_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      s_rdata <= '0; s_rresp <= '0; s_bresp <= '0;
    end else begin
      if (s_arvalid && s_arready) begin
        sl_raddr <= s_araddr;
        sl_cnt   <= 2;
      end else if (sl_cnt > 1) begin
        sl_cnt <= sl_cnt - 1;
      end else if (sl_cnt == 1) begin
        sl_cnt   <= 0;
        s_rvalid <= 1'b1;
        s_rdata  <= (sl_raddr[31:28] == 4'hF) ? 32'h0 : mem[idx(sl_raddr)];
        s_rresp  <= (sl_raddr[31:28] == 4'hF) ? 2'd2 : 2'd0;
      end
      if (s_rvalid && s_rready) s_rvalid <= 1'b0;
      if (s_awvalid && s_awready) begin sl_waddr <= s_awaddr; aw_got <= 1'b1; end
      if (s_wvalid && s_wready) begin sl_wdata <= s_wdata; sl_wstrb <= s_wstrb; w_got <= 1'b1; end
      if (aw_got && w_got) begin
        if (sl_waddr[31:28] != 4'hF)
          for (int b = 0; b < 4; b++)
            if (sl_wstrb[b]) mem[idx(sl_waddr)][8*b +: 8] <= sl_wdata[8*b +: 8];
        s_bresp  <= (sl_waddr[31:28] == 4'hF) ? 2'd2 : 2'd0;
        s_bvalid <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
    end
  end

  // Handshake and grant monitors
  typedef struct packed { logic own; logic wr; } gr_t;
  gr_t grants[$];
  int  n_aw = 0, n_w = 0, n_b = 0, n_wrise = 0;
  logic prev_busy = 1'b0, prev_wv = 1'b0;
  always @(posedge clk) begin
    if (busy && !prev_busy) grants.push_back({owner, ~s_arvalid});
    prev_busy <= busy;
    prev_wv   <= s_wvalid;
    if (s_wvalid && !prev_wv) n_wrise <= n_wrise + 1;
    if (s_awvalid && s_awready) n_aw <= n_aw + 1;
    if (s_wvalid && s_wready) n_w <= n_w + 1;
    if (s_bvalid && s_bready) n_b <= n_b + 1;
  end

  int n_checks = 0, n_err = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: no handshake within %0d cycles", name, CYC);
  endtask

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } exp_t;
  exp_t q_r0[$], q_r1[$], q_b1[$];

  task automatic m0_read(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er, output int lat);
    int c;
    exp_t e;
    q_r0.push_back({ed, er});
    m0_araddr = addr; m0_arvalid = 1'b1; m0_rready = 1'b1;
    c = 0;
    while (!m0_arready && c < CYC) begin @(negedge clk); c++; end
    lat = c;
    if (c >= CYC) begin fail("m0_ar"); m0_arvalid = 1'b0; void'(q_r0.pop_back()); return; end
    @(negedge clk);
    m0_arvalid = 1'b0;
    c = 0;
    while (!m0_rvalid && c < CYC) begin @(negedge clk); c++; end
    if (c >= CYC) begin fail("m0_r"); void'(q_r0.pop_back()); return; end
    e = q_r0.pop_front();
    chk("m0_rdata", m0_rdata, e.data);
    chk("m0_rresp", m0_rresp, e.resp);
    chk("m1_rvalid_while_m0", m1_rvalid, 1'b0);
    @(negedge clk);
    chk("busy_after_m0_r", busy, 1'b0);
  endtask

  task automatic m1_read(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er);
    int c;
    exp_t e;
    q_r1.push_back({ed, er});
    m1_araddr = addr; m1_arvalid = 1'b1; m1_rready = 1'b1;
    c = 0;
    while (!m1_arready && c < CYC) begin @(negedge clk); c++; end
    if (c >= CYC) begin fail("m1_ar"); m1_arvalid = 1'b0; void'(q_r1.pop_back()); return; end
    @(negedge clk);
    m1_arvalid = 1'b0;
    c = 0;
    while (!m1_rvalid && c < CYC) begin @(negedge clk); c++; end
    if (c >= CYC) begin fail("m1_r"); void'(q_r1.pop_back()); return; end
    e = q_r1.pop_front();
    chk("m1_rdata", m1_rdata, e.data);
    chk("m1_rresp", m1_rresp, e.resp);
    chk("m0_rvalid_while_m1", m0_rvalid, 1'b0);
    @(negedge clk);
    chk("busy_after_m1_r", busy, 1'b0);
  endtask

  task automatic m1_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input logic [1:0] er);
    int c;
    logic haw, hw;
    bit awd, wd;
    exp_t e;
    q_b1.push_back({32'h0, er});
    m1_awaddr = addr; m1_wdata = data; m1_wstrb = strb; m1_bready = 1'b1;
    m1_wvalid = 1'b1; m1_awvalid = (lead == 0);
    c = 0; awd = 0; wd = 0;
    while (!(awd && wd) && c < CYC) begin
      haw = m1_awvalid & m1_awready;
      hw  = m1_wvalid & m1_wready;
      @(negedge clk); c++;
      if (haw) begin awd = 1; m1_awvalid = 1'b0; end
      if (hw) begin wd = 1; m1_wvalid = 1'b0; end
      if (!awd && c >= lead) m1_awvalid = 1'b1;
    end
    if (!(awd && wd)) begin
      fail("m1_aw_w"); m1_awvalid = 1'b0; m1_wvalid = 1'b0; void'(q_b1.pop_back()); return;
    end
    c = 0;
    while (!m1_bvalid && c < CYC) begin @(negedge clk); c++; end
    if (c >= CYC) begin fail("m1_b"); void'(q_b1.pop_back()); return; end
    e = q_b1.pop_front();
    chk("m1_bresp", m1_bresp, e.resp);
    @(negedge clk);
    chk("busy_after_m1_b", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[8];
  logic exp_own[4];
  int   lat, s_aw, s_w, s_b, s_wr;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h1000_AAAA, 2'd0};
    vecs[2] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h0011_2233, 2'd0};
    vecs[3] = '{1'b1, 1'b1, 32'h8000_3000, 32'hCAFE_F00D, 4'h3, 32'h0, 2'd0};
    vecs[4] = '{1'b1, 1'b0, 32'h8000_3000, 32'h0, 4'h0, 32'h0000_F00D, 2'd0};
    vecs[5] = '{1'b1, 1'b1, 32'hF000_0000, 32'h1234_5678, 4'hF, 32'h0, 2'd2};
    vecs[6] = '{1'b0, 1'b0, 32'hF000_0004, 32'h0, 4'h0, 32'h0, 2'd2};
    vecs[7] = '{1'b1, 1'b0, 32'hF000_0008, 32'h0, 4'h0, 32'h0, 2'd2};
`ifdef AXI_ARB_LSU_PRIO_EN
    exp_own = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
    m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
    rst = 1'b1; preload = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; preload = 1'b0;
    @(negedge clk);

    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 5'b0);
    chk("rst_m_readies", {m0_arready, m1_arready, m1_awready, m1_wready}, 4'b0);
    chk("rst_m_valids", {m0_rvalid, m1_rvalid, m1_bvalid}, 3'b0);
    chk("rst_s_araddr", s_araddr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].m) m0_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, lat);
      else if (vecs[i].wr) m1_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, vecs[i].exp_resp);
      else m1_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end

    // W leads AW by two cycles: exactly one handshake each, W never re-raised
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_wr = n_wrise;
    m1_write(32'h8000_2000, 32'hDEAD_BEEF, 4'hF, 2, 2'd0);
    @(negedge clk);
    chk("wlead_aw_count", n_aw - s_aw, 1);
    chk("wlead_w_count", n_w - s_w, 1);
    chk("wlead_b_count", n_b - s_b, 1);
    chk("wlead_wvalid_rises", n_wrise - s_wr, 1);

    // LSU read and write pending together: write first, then read
    grants.delete();
    fork
      m1_write(32'h8000_3004, 32'h5555_AAAA, 4'hF, 0, 2'd0);
      m1_read(32'h8000_2000, 32'hDEAD_BEEF, 2'd0);
    join
    chk("rw_grant_count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("rw_first_is_write", grants[0].wr, 1'b1);
      chk("rw_second_is_read", grants[1].wr, 1'b0);
    end
    m1_read(32'h8000_3004, 32'h5555_AAAA, 2'd0);

    // Both masters reading continuously from reset
    do_reset();
    grants.delete();
    fork
      begin
        m0_read(32'h8000_0004, 32'h0011_2233, 2'd0, lat);
        m0_read(32'h8000_0000, 32'h0000_0413, 2'd0, lat);
      end
      begin
        m1_read(32'h8000_1000, 32'h1000_AAAA, 2'd0);
        m1_read(32'h8000_3000, 32'h0000_F00D, 2'd0);
      end
    join
    chk("tie_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk($sformatf("tie_owner_%0d", i), grants[i].own, exp_own[i]);

    // Reset after AR accepted, before R
    do_reset();
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b1;
    for (int c = 0; c < CYC && !m0_arready; c++) @(negedge clk);
    chk("midrst_ar_accepted", m0_arready, 1'b1);
    @(negedge clk);
    m0_arvalid = 1'b0;
    chk("midrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_owner", owner, 1'b0);
    chk("midrst_s_ctl", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 5'b0);
    chk("midrst_m_ctl", {m0_arready, m0_rvalid, m1_rvalid, m1_bvalid}, 4'b0);
    chk("midrst_s_araddr", s_araddr, 32'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("midrst_no_late_r", m0_rvalid, 1'b0);
    m0_read(32'h8000_0004, 32'h0011_2233, 2'd0, lat);
    chk("m0_grant_latency", lat, 1);

    chk("scoreboard_empty", q_r0.size() + q_r1.size() + q_b1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
